// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: five-byte UART frame (A lo/hi, B lo/hi, opcode)
// drives a combinational ALU, then returns the 16-bit result as two
// transmitted bytes (low byte first) through the start/done handshake.
module alu_uart_sequencer #(
    parameter int BUS_REG  = 16,
    parameter int BUS_OP   = 6,
    parameter int BUS_BYTE = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [BUS_BYTE-1:0] i_rx_data,
    input  logic                i_rx_done,
    input  logic                i_tx_done,
    input  logic [BUS_REG-1:0]  i_result,
    output logic [BUS_REG-1:0]  o_valA,
    output logic [BUS_REG-1:0]  o_valB,
    output logic [BUS_OP-1:0]   o_opcode,
    output logic [BUS_BYTE-1:0] o_tx_data,
    output logic                o_tx_start,
    output logic                o_busy,
    output logic                o_overrun
);

    typedef enum logic [3:0] {
        A_LO, A_HI, B_LO, B_HI, OP,
        EXEC, TX_LO, WAIT_LO, TX_HI, WAIT_HI
    } state_t;

    state_t              state_q, state_d;
    logic [BUS_REG-1:0]  shA_q, shA_d;
    logic [BUS_REG-1:0]  shB_q, shB_d;
    logic [BUS_REG-1:0]  valA_q, valA_d;
    logic [BUS_REG-1:0]  valB_q, valB_d;
    logic [BUS_OP-1:0]   opcode_q, opcode_d;
    logic [BUS_REG-1:0]  result_q, result_d;
    logic [BUS_BYTE-1:0] tx_data_q, tx_data_d;

    // Opcode byte upper bits and the low result byte (forwarded straight
    // from i_result at capture) have no other reader.
    logic unused_bits;
    assign unused_bits = ^{i_rx_data[BUS_BYTE-1:BUS_OP], result_q[BUS_BYTE-1:0]};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= A_LO;
            shA_q     <= '0;
            shB_q     <= '0;
            valA_q    <= '0;
            valB_q    <= '0;
            opcode_q  <= '0;
            result_q  <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            shA_q     <= shA_d;
            shB_q     <= shB_d;
            valA_q    <= valA_d;
            valB_q    <= valB_d;
            opcode_q  <= opcode_d;
            result_q  <= result_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Next-state, byte assembly, result capture and handshake outputs.
    always_comb begin
        state_d    = state_q;
        shA_d      = shA_q;
        shB_d      = shB_q;
        valA_d     = valA_q;
        valB_d     = valB_q;
        opcode_d   = opcode_q;
        result_d   = result_q;
        tx_data_d  = tx_data_q;
        o_tx_start = 1'b0;
        o_busy     = 1'b0;
        unique case (state_q)
            A_LO: if (i_rx_done) begin
                shA_d[BUS_BYTE-1:0] = i_rx_data;
                state_d = A_HI;
            end
            A_HI: if (i_rx_done) begin
                shA_d[BUS_REG-1:BUS_BYTE] = i_rx_data;
                state_d = B_LO;
            end
            B_LO: if (i_rx_done) begin
                shB_d[BUS_BYTE-1:0] = i_rx_data;
                state_d = B_HI;
            end
            B_HI: if (i_rx_done) begin
                shB_d[BUS_REG-1:BUS_BYTE] = i_rx_data;
                state_d = OP;
            end
            OP: if (i_rx_done) begin
                valA_d   = shA_q;
                valB_d   = shB_q;
                opcode_d = i_rx_data[BUS_OP-1:0];
                state_d  = EXEC;
            end
            EXEC: begin
                o_busy   = 1'b1;
                result_d = i_result;
                // Low byte preloaded here so it is already on o_tx_data in TX_LO.
                tx_data_d = i_result[BUS_BYTE-1:0];
                state_d  = TX_LO;
            end
            TX_LO: begin
                o_busy     = 1'b1;
                o_tx_start = 1'b1;
                state_d    = WAIT_LO;
            end
            WAIT_LO: begin
                o_busy = 1'b1;
                if (i_tx_done) begin
                    tx_data_d = result_q[BUS_REG-1:BUS_BYTE];
                    state_d   = TX_HI;
                end
            end
            TX_HI: begin
                o_busy     = 1'b1;
                o_tx_start = 1'b1;
                state_d    = WAIT_HI;
            end
            WAIT_HI: begin
                o_busy = 1'b1;
                if (i_tx_done) state_d = A_LO;
            end
            default: state_d = A_LO;
        endcase
        o_overrun = o_busy & i_rx_done;
    end

    assign o_valA    = valA_q;
    assign o_valB    = valB_q;
    assign o_opcode  = opcode_q;
    assign o_tx_data = tx_data_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Testbench for alu_uart_sequencer: drives UART frames, models the ALU,
// and checks transmitted bytes against a scoreboard of expected bytes.
module tb_alu_uart_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        tx_done;
    logic [15:0] result;
    logic [15:0] valA, valB;
    logic [5:0]  opcode;
    logic [7:0]  tx_data;
    logic        tx_start, busy, overrun;

    int checks = 0;
    int passed = 0;
    logic [7:0] exp_q[$];

    alu_uart_sequencer #(.BUS_REG(16), .BUS_OP(6), .BUS_BYTE(8)) dut (
        .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_tx_done(tx_done), .i_result(result), .o_valA(valA), .o_valB(valB),
        .o_opcode(opcode), .o_tx_data(tx_data), .o_tx_start(tx_start),
        .o_busy(busy), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    // Combinational ALU stand-in: 0x20 add, 0x02 sub, 0x27 nor.
    always_comb begin
        case (opcode)
            6'h20:   result = valA + valB;
            6'h02:   result = valA - valB;
            6'h27:   result = ~(valA | valB);
            default: result = 16'h0000;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(b[7:0]);
        send_byte(b[15:8]);
        send_byte(op);
    endtask

    // Cycles until o_tx_start (0 = already high), -1 on timeout.
    task automatic wait_tx_start(output int cyc, output logic [7:0] d);
        bit found = 0;
        cyc = -1;
        d = 8'h00;
        for (int i = 0; i < 200 && !found; i++) begin
            if (tx_start === 1'b1) begin
                cyc = i;
                d = tx_data;
                found = 1;
            end else begin
                step();
            end
        end
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    function automatic logic [7:0] pop_exp();
        if (exp_q.size() == 0) return 8'hxx;
        return exp_q.pop_front();
    endfunction

    // Serves both transmit bytes; hold = idle cycles spent in WAIT_LO.
    task automatic run_tx(input int hold, output int c_lo, output logic [7:0] d_lo,
                          output int c_hi, output logic [7:0] d_hi);
        wait_tx_start(c_lo, d_lo);
        step();
        repeat (hold) step();
        pulse_tx_done();
        wait_tx_start(c_hi, d_hi);
        step();
        pulse_tx_done();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_done = 1'b1; rx_data = 8'hFF; tx_done = 1'b0;
        step(); step();
        checks++;
        if ({valA, valB, opcode, tx_data, tx_start, busy, overrun} !== '0)
            $display("FAIL reset_outputs: got %h/%h/%h/%h/%b/%b/%b required all zero",
                     valA, valB, opcode, tx_data, tx_start, busy, overrun);
        else passed++;
        rst = 1'b0; rx_done = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b required 0", busy);
        else passed++;
    endtask

    task automatic test_add();
        int c; logic [7:0] d, e;
        send_frame(16'h1234, 16'h0001, 8'h20);
        exp_q.push_back(8'h35); exp_q.push_back(8'h12);
        checks++;
        if ({valA, valB, opcode} !== {16'h1234, 16'h0001, 6'h20})
            $display("FAIL add_operands: got %h %h %h required 1234 0001 20", valA, valB, opcode);
        else passed++;
        checks++;
        if (busy !== 1'b1) $display("FAIL add_exec_busy: got %b required 1", busy);
        else passed++;
        wait_tx_start(c, d);
        e = pop_exp();
        checks++;
        if (c !== 1) $display("FAIL add_latency: got %0d cycles after EXEC required 1", c);
        else passed++;
        checks++;
        if (d !== e) $display("FAIL add_lo_byte: got %h required %h", d, e);
        else passed++;
        step();
        checks++;
        if (tx_start !== 1'b0) $display("FAIL add_start_single: got %b required 0", tx_start);
        else passed++;
        step(); step();
        pulse_tx_done();
        wait_tx_start(c, d);
        e = pop_exp();
        checks++;
        if (c !== 0 || d !== e) $display("FAIL add_hi_byte: got %h after %0d required %h after 0", d, c, e);
        else passed++;
        step();
        pulse_tx_done();
        checks++;
        if (busy !== 1'b0) $display("FAIL add_return_idle: got busy %b required 0", busy);
        else passed++;
    endtask

    task automatic test_sub_nor();
        int c0, c1; logic [7:0] d0, d1, e0, e1;
        send_frame(16'h0005, 16'h0007, 8'h02);
        exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
        run_tx(5, c0, d0, c1, d1);
        e0 = pop_exp(); e1 = pop_exp();
        checks++;
        if (c0 < 0 || c1 < 0 || d0 !== e0 || d1 !== e1)
            $display("FAIL sub_wrap: got %h %h required %h %h", d0, d1, e0, e1);
        else passed++;
        send_frame(16'h00F0, 16'h0F00, 8'hE7);
        exp_q.push_back(8'h0F); exp_q.push_back(8'hF0);
        checks++;
        if (opcode !== 6'h27) $display("FAIL nor_opcode_mask: got %h required 27", opcode);
        else passed++;
        run_tx(0, c0, d0, c1, d1);
        e0 = pop_exp(); e1 = pop_exp();
        checks++;
        if (c0 < 0 || c1 < 0 || d0 !== e0 || d1 !== e1)
            $display("FAIL nor_result: got %h %h required %h %h", d0, d1, e0, e1);
        else passed++;
    endtask

    task automatic test_overrun();
        int c, c1; logic [7:0] d, d1, e, e1;
        send_frame(16'h00FF, 16'h0001, 8'h20);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        wait_tx_start(c, d);
        e = pop_exp();
        step();
        rx_data = 8'hAA; rx_done = 1'b1;
        #1;
        checks++;
        if (overrun !== 1'b1) $display("FAIL overrun_pulse: got %b required 1", overrun);
        else passed++;
        step();
        rx_done = 1'b0;
        #1;
        checks++;
        if (overrun !== 1'b0 || tx_start !== 1'b0) $display("FAIL overrun_one_cycle: got ovr %b start %b required 0 0", overrun, tx_start);
        else passed++;
        pulse_tx_done();
        wait_tx_start(c1, d1);
        e1 = pop_exp();
        step();
        pulse_tx_done();
        checks++;
        if (c < 0 || c1 !== 0 || d !== e || d1 !== e1)
            $display("FAIL overrun_tx: got %h %h required %h %h", d, d1, e, e1);
        else passed++;
        // Back-to-back: frame begins in the cycle right after the final done.
        send_frame(16'h0010, 16'h0003, 8'h02);
        exp_q.push_back(8'h0D); exp_q.push_back(8'h00);
        checks++;
        if (valA !== 16'h0010 || valB !== 16'h0003) $display("FAIL b2b_operands: got %h %h required 0010 0003", valA, valB);
        else passed++;
        run_tx(1, c, d, c1, d1);
        e = pop_exp(); e1 = pop_exp();
        checks++;
        if (c < 0 || c1 < 0 || d !== e || d1 !== e1)
            $display("FAIL b2b_result: got %h %h required %h %h", d, d1, e, e1);
        else passed++;
    endtask

    task automatic test_handshake();
        int c, n; logic [7:0] d, e;
        send_frame(16'h0100, 16'h0002, 8'h20);
        exp_q.push_back(8'h02); exp_q.push_back(8'h01);
        wait_tx_start(c, d);
        e = pop_exp();
        checks++;
        if (c < 0 || d !== e) $display("FAIL hs_lo_byte: got %h required %h", d, e);
        else passed++;
        tx_done = 1'b1;          // in TX_LO: must be ignored
        step();
        tx_done = 1'b0;
        n = 0;
        repeat (50) begin
            if (tx_start === 1'b1) n++;
            step();
        end
        checks++;
        if (n !== 0 || busy !== 1'b1) $display("FAIL hs_hold: got %0d starts busy %b required 0 starts busy 1", n, busy);
        else passed++;
        pulse_tx_done();
        wait_tx_start(c, d);
        e = pop_exp();
        checks++;
        if (c !== 0 || d !== e) $display("FAIL hs_hi_byte: got %h after %0d required %h after 0", d, c, e);
        else passed++;
        step();
        n = 0;
        repeat (10) begin
            if (tx_start === 1'b1) n++;
            step();
        end
        checks++;
        if (n !== 0) $display("FAIL hs_single_hi: got %0d extra starts required 0", n);
        else passed++;
        pulse_tx_done();
    endtask

    task automatic test_reset_midframe();
        int c0, c1, n; logic [7:0] d0, d1, e0, e1;
        // Reset while waiting on the low-byte done abandons the transmit.
        send_frame(16'h0001, 16'h0002, 8'h20);
        wait_tx_start(c0, d0);
        step();
        rst = 1'b1; step(); rst = 1'b0;
        n = 0;
        repeat (20) begin
            if (tx_start === 1'b1) n++;
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
        end
        checks++;
        if (n !== 0 || busy !== 1'b0) $display("FAIL reset_abandon_tx: got %0d starts busy %b required 0 0", n, busy);
        else passed++;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        rst = 1'b1;
        step();
        checks++;
        if ({valA, valB, opcode, tx_data, tx_start, busy, overrun} !== '0)
            $display("FAIL reset_midframe_outputs: got %h/%h/%h/%h/%b/%b/%b required all zero",
                     valA, valB, opcode, tx_data, tx_start, busy, overrun);
        else passed++;
        rst = 1'b0;
        step();
        send_frame(16'h0001, 16'h0001, 8'h20);
        exp_q.push_back(8'h02); exp_q.push_back(8'h00);
        checks++;
        if (valA !== 16'h0001 || valB !== 16'h0001) $display("FAIL reset_reframe_operands: got %h %h required 0001 0001", valA, valB);
        else passed++;
        run_tx(2, c0, d0, c1, d1);
        e0 = pop_exp(); e1 = pop_exp();
        checks++;
        if (c0 < 0 || c1 < 0 || d0 !== e0 || d1 !== e1)
            $display("FAIL reset_reframe_result: got %h %h required %h %h", d0, d1, e0, e1);
        else passed++;
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
        test_reset();
        test_add();
        test_sub_nor();
        test_overrun();
        test_handshake();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
